// File: rtl/serial_pkg.sv
// Shared definitions for the 8N1 serial link (transmitter and receiver).
// Bit timing is derived once here so both ends agree on the baud rate.
package serial_pkg;
  localparam int SERIAL_CLK_HZ = 50_000_000;
  localparam int SERIAL_BAUD   = 10_000;
  localparam int CLKS_PER_BIT  = SERIAL_CLK_HZ / SERIAL_BAUD;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rcv_state_t;
endpackage

// File: rtl/rcv_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input pin.
// Latency 2 clocks; both flops reset to 1 so a reset never looks like a start edge.
module rcv_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/rcv.sv
// 8N1 serial receiver into a one-byte holding register with sticky framing/overrun flags.
// full rises one clock after the stop-bit centre; no line back-pressure, a byte arriving while full is dropped.
module rcv #(
  parameter int CLKS_PER_BIT = serial_pkg::CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       read,
  input  logic       err_clr,
  output logic [7:0] data_out,
  output logic       full,
  output logic       framing_err,
  output logic       overrun
);
  import serial_pkg::*;

  localparam logic [31:0] HALF_M1 = 32'(HALF_BIT - 1);
  localparam logic [31:0] FULL_M1 = 32'(CLKS_PER_BIT - 1);

  rcv_state_t  state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  sh, sh_nxt;
  logic        rxd_s;
  logic        deliver, frame_bad;

  rcv_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rxd),
    .q       (rxd_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_nxt = START;
          cnt_nxt   = HALF_M1;
        end
      end
      START: begin
        if (cnt == '0) begin
          // A start bit that is gone by its centre was noise.
          if (rxd_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            idx_nxt   = 3'd0;
            cnt_nxt   = FULL_M1;
          end
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          sh_nxt  = {rxd_s, sh[7:1]};
          cnt_nxt = FULL_M1;
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rxd_s) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      BREAK: begin
        // Hold off until the line returns high so a stuck-low line yields one event.
        if (rxd_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      data_out    <= '0;
      full        <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      sh    <= sh_nxt;
      if (deliver && (!full || read)) begin
        data_out <= sh;
        full     <= 1'b1;
      end else if (read) begin
        full <= 1'b0;
      end
      framing_err <= (framing_err & ~err_clr) | frame_bad;
      overrun     <= (overrun & ~err_clr) | (deliver & full & ~read);
    end
  end
endmodule

// File: tb/tb_rcv.sv
// Directed test of the serial receiver with a 16-clock bit period.
module tb_rcv;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       rxd;
  logic       read;
  logic       err_clr;
  logic [7:0] data_out;
  logic       full;
  logic       framing_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  rcv #(.CLKS_PER_BIT(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rxd         (rxd),
    .read        (read),
    .err_clr     (err_clr),
    .data_out    (data_out),
    .full        (full),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives start and data bits, sets the stop bit, and returns one clock
  // before the delivery edge (stop centre is 155 edges after the start edge).
  task automatic send_to_stop(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(16);
    end
    rxd = stop;
    tick(10);
  endtask

  task automatic pulse_read();
    read = 1'b1;
    tick(1);
    read = 1'b0;
  endtask

  // Full good frame followed by a read; checks delivery edge, data and flags.
  task automatic good_frame(input logic [7:0] b, input string tag);
    send_to_stop(b, 1'b1);
    chk({tag, "_full_early"}, {7'd0, full}, 8'd0);
    tick(1);
    chk({tag, "_full"}, {7'd0, full}, 8'd1);
    chk({tag, "_data"}, data_out, b);
    chk({tag, "_ferr"}, {7'd0, framing_err}, 8'd0);
    chk({tag, "_ovr"}, {7'd0, overrun}, 8'd0);
    tick(5);
    pulse_read();
    chk({tag, "_read_full"}, {7'd0, full}, 8'd0);
    chk({tag, "_read_data"}, data_out, b);
  endtask

  initial begin
    reset_n = 1'b0;
    rxd     = 1'b1;
    read    = 1'b0;
    err_clr = 1'b0;
    tick(3);
    chk("rst_data", data_out, 8'h00);
    chk("rst_full", {7'd0, full}, 8'd0);
    chk("rst_ferr", {7'd0, framing_err}, 8'd0);
    chk("rst_ovr", {7'd0, overrun}, 8'd0);
    reset_n = 1'b1;
    tick(4);

    good_frame(8'hA5, "a5");
    good_frame(8'h00, "b00");
    good_frame(8'hFF, "bff");

    // Start glitch shorter than half a bit.
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(30);
    chk("glitch_full", {7'd0, full}, 8'd0);
    chk("glitch_ferr", {7'd0, framing_err}, 8'd0);
    chk("glitch_ovr", {7'd0, overrun}, 8'd0);
    good_frame(8'h3C, "g3c");

    // Framing error with the line held low afterwards.
    send_to_stop(8'h55, 1'b0);
    tick(1);
    chk("fe_flag", {7'd0, framing_err}, 8'd1);
    chk("fe_full", {7'd0, full}, 8'd0);
    chk("fe_data", data_out, 8'h3C);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("fe_clr", {7'd0, framing_err}, 8'd0);
    tick(44);
    rxd = 1'b1;
    tick(200);
    chk("fe_no_frame_full", {7'd0, full}, 8'd0);
    chk("fe_no_second_err", {7'd0, framing_err}, 8'd0);
    chk("fe_no_frame_data", data_out, 8'h3C);
    good_frame(8'h12, "f12");

    // Overrun: second byte arrives with no read.
    send_to_stop(8'h11, 1'b1);
    tick(6);
    chk("ov1_data", data_out, 8'h11);
    send_to_stop(8'h22, 1'b1);
    tick(1);
    chk("ov_data", data_out, 8'h11);
    chk("ov_full", {7'd0, full}, 8'd1);
    chk("ov_flag", {7'd0, overrun}, 8'd1);
    tick(5);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ov_clr", {7'd0, overrun}, 8'd0);

    // Same again with read in the delivery cycle.
    send_to_stop(8'h22, 1'b1);
    read = 1'b1;
    tick(1);
    read = 1'b0;
    chk("ovr_read_data", data_out, 8'h22);
    chk("ovr_read_full", {7'd0, full}, 8'd1);
    chk("ovr_read_flag", {7'd0, overrun}, 8'd0);
    tick(5);
    pulse_read();
    chk("ovr_read_empty", {7'd0, full}, 8'd0);

    // Reset during data bit 3 of 0x81; the line is then released.
    rxd = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      rxd = 8'h81 >> i;
      tick(16);
    end
    rxd = 1'b0;
    tick(8);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("mrst_data", data_out, 8'h00);
    chk("mrst_full", {7'd0, full}, 8'd0);
    chk("mrst_ferr", {7'd0, framing_err}, 8'd0);
    chk("mrst_ovr", {7'd0, overrun}, 8'd0);
    rxd = 1'b1;
    tick(200);
    chk("mrst_no_byte", {7'd0, full}, 8'd0);
    chk("mrst_no_err", {7'd0, framing_err}, 8'd0);
    good_frame(8'h81, "r81");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
